// File: rtl/mdio_pkg.sv
// Shared types and Clause-22 frame constants for the MDIO management master.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_TA       = 3'd3,
        S_DATA     = 3'd4
    } state_t;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int FRAME_LEN  = 32;
    localparam int HEADER_LEN = 14;
    localparam int TA_LEN     = 2;
    localparam int DATA_LEN   = 16;

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: one bit period is 2*CLK_DIV clk cycles, low half first.
// o_rise marks the first high cycle; o_fall marks the last high cycle (MDC drops after it).
module mdio_clk_div #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_mdc,
    output logic o_fall,
    output logic o_rise
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_reset || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_mdc  = (r_cnt >= C_HALF);
    assign o_rise = i_en && (r_cnt == C_HALF);
    assign o_fall = i_en && (r_cnt == C_LAST);

endmodule

// File: rtl/mdio_rw_master.sv
// Clause-22 MDIO read/write master with open-drain style io_mdio and generated MDC.
//   state      | meaning
//   S_IDLE     | bus released, MDC low, waiting for i_start
//   S_PREAMBLE | driving PREAMBLE_LEN ones
//   S_HEADER   | driving ST, OP, PHYAD, REGAD (14 bits)
//   S_TA       | write: drive 10; read: release, sample second bit as no-PHY flag
//   S_DATA     | write: drive 16 data bits; read: release and shift in 16 bits
module mdio_rw_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_rd_err,
    output logic        o_done,
    output logic        o_busy,
    inout  wire         io_mdio,
    output logic        o_mdc
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_LEN-1:0]   r_frame;
    logic                   r_write;
    logic [DATA_LEN-1:0]    r_rx;
    logic                   r_ta_bit;
    logic [DATA_LEN-1:0]    r_rdata;
    logic                   r_rd_err;
    logic                   r_done;

    logic w_fall;
    logic w_rise;
    logic w_accept;
    logic w_last_bit;
    logic w_busy;
    logic w_oe;
    logic w_out;

    mdio_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .i_reset (i_reset),
        .i_en    (w_busy),
        .o_mdc   (o_mdc),
        .o_fall  (w_fall),
        .o_rise  (w_rise)
    );

    assign w_accept = i_start && (r_state == S_IDLE);

    always_comb begin
        w_last_bit = 1'b0;
        case (r_state)
            S_PREAMBLE: w_last_bit = (r_bit_cnt == CNT_W'(PREAMBLE_LEN - 1));
            S_HEADER:   w_last_bit = (r_bit_cnt == CNT_W'(HEADER_LEN - 1));
            S_TA:       w_last_bit = (r_bit_cnt == CNT_W'(TA_LEN - 1));
            S_DATA:     w_last_bit = (r_bit_cnt == CNT_W'(DATA_LEN - 1));
            default:    w_last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = (PREAMBLE_LEN == 0) ? S_HEADER : S_PREAMBLE;
                end
            end
            S_PREAMBLE: if (w_fall && w_last_bit) w_next_state = S_HEADER;
            S_HEADER:   if (w_fall && w_last_bit) w_next_state = S_TA;
            S_TA:       if (w_fall && w_last_bit) w_next_state = S_DATA;
            S_DATA:     if (w_fall && w_last_bit) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Bus ownership: master drives everything on writes, only up to REGAD on reads.
    always_comb begin
        w_busy = 1'b1;
        w_oe   = 1'b0;
        w_out  = 1'b1;
        case (r_state)
            S_IDLE:     w_busy = 1'b0;
            S_PREAMBLE: w_oe   = 1'b1;
            S_HEADER: begin
                w_oe  = 1'b1;
                w_out = r_frame[FRAME_LEN-1];
            end
            S_TA, S_DATA: begin
                w_oe  = r_write;
                w_out = r_frame[FRAME_LEN-1];
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_write   <= 1'b0;
            r_rx      <= '0;
            r_ta_bit  <= 1'b0;
            r_rdata   <= '0;
            r_rd_err  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_write   <= i_write;
                r_frame   <= {ST, (i_write ? OP_WRITE : OP_READ), i_phy_addr, i_reg_addr,
                              TA_WRITE, i_wdata};
                r_bit_cnt <= '0;
            end else if (w_fall) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                if (r_state != S_PREAMBLE) begin
                    r_frame <= {r_frame[FRAME_LEN-2:0], 1'b0};
                end
                if (r_state == S_DATA && w_last_bit) begin
                    r_done <= 1'b1;
                    if (!r_write) begin
                        r_rdata  <= r_rx;
                        r_rd_err <= r_ta_bit;
                    end
                end
            end
            // The second TA bit floats high when no PHY answers.
            if (w_rise && !r_write) begin
                if (r_state == S_TA && r_bit_cnt == CNT_W'(1)) begin
                    r_ta_bit <= io_mdio;
                end
                if (r_state == S_DATA) begin
                    r_rx <= {r_rx[DATA_LEN-2:0], io_mdio};
                end
            end
        end
    end

    assign io_mdio  = w_oe ? w_out : 1'bz;
    assign o_busy   = w_busy;
    assign o_done   = r_done;
    assign o_rdata  = r_rdata;
    assign o_rd_err = r_rd_err;

endmodule

// File: doc/mdio_rw_master.md
MDIO_RW_MASTER -- requirements
Module: mdio_rw_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10: MDC half-period in clk cycles; legal range >= 2.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 32: number of preamble ones; legal range 0..32, where 0 means preamble suppressed.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_start  input  1  transaction request; accepted only while o_busy=0.
REQ-007 i_write  input  1  1=write, 0=read; sampled at accept.
REQ-008 i_phy_addr  input  5  PHY address; sampled at accept.
REQ-009 i_reg_addr  input  5  register address; sampled at accept.
REQ-010 i_wdata  input  16  write data; sampled at accept.
REQ-011 o_rdata  output  16  last read data.
REQ-012 o_rd_err  output  1  last read saw no PHY response (TA bit 2 sampled 1).
REQ-013 o_done  output  1  one-cycle completion pulse.
REQ-014 o_busy  output  1  transaction in progress.
REQ-015 io_mdio  inout  1  MDIO; driven 0/1 or released to Z (external pull-up).
REQ-016 o_mdc  output  1  MDIO management clock.

Function
REQ-017 Accept: on a cycle with i_start=1 and o_busy=0, latch all inputs, and set o_busy=1 from the next cycle; i_start while busy SHALL be ignored.
REQ-018 Clause-22 frame, MSB first: PREAMBLE_LEN ones, ST=01, OP (write 01 / read 10), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]; total PREAMBLE_LEN+32 bits.
REQ-019 Each bit SHALL occupy one MDC period = 2*CLK_DIV clk cycles: MDC low for the first CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-020 The master SHALL update io_mdio at the start of each MDC low phase and sample it on the clk cycle where o_mdc rises.
REQ-021 Write TA SHALL drive "10", then drive DATA.
REQ-022 Read TA SHALL release io_mdio for both TA bits and all DATA bits; the second TA bit is sampled into o_rd_err (1 = no PHY).
REQ-023 Read DATA bits SHALL shift into an internal register; on completion, o_rdata SHALL take the assembled value even if o_rd_err=1.
REQ-024 A write SHALL leave o_rdata and o_rd_err unchanged.
REQ-025 o_busy SHALL stay high for exactly (PREAMBLE_LEN+32)*2*CLK_DIV cycles; o_done SHALL pulse in the first cycle o_busy=0.
REQ-026 At o_done, o_rdata and o_rd_err SHALL be valid.
REQ-027 A new i_start SHALL be accepted in the o_done cycle.
REQ-028 Idle: o_mdc=0, io_mdio released, and the divider counter held at 0.
REQ-029 FSM states: IDLE -> PREAMBLE (skipped when PREAMBLE_LEN=0) -> HEADER (ST/OP/PHYAD/REGAD, 14 bits) -> TA -> DATA -> IDLE.
REQ-030 Bit counter SHALL be sized to hold 32; no wrap occurs within a frame.

Reset
REQ-031 On i_reset, including mid-frame, the next cycle SHALL give: state IDLE, o_busy=0, o_done=0, o_mdc=0, io_mdio released, o_rdata=16'h0000, o_rd_err=0, and all counters cleared.
REQ-032 i_start coincident with i_reset SHALL be ignored.

Structure
REQ-033 Package mdio_pkg SHALL hold: the state enum, ST=2'b01, OP_WRITE=2'b01, OP_READ=2'b10, TA_WRITE=2'b10, and the frame-length constant 32.
REQ-034 Sub-module mdio_clk_div SHALL be used: CLK_DIV-parametrised; enable input; outputs o_mdc, a fall strobe and a rise strobe.

Verification
REQ-035 Write test, CLK_DIV=2, PREAMBLE_LEN=32, phy 5'h01, reg 5'h00, wdata 16'h1234 -> bits captured on MDC rise = 32x1, 01, 01, 00001, 00000, 10, 0001001000110100; o_busy high for 256 cycles; one o_done pulse.
REQ-036 Read test with a bench PHY model driving TA0=0 and 16'hBEEF, phy 5'h03, reg 5'h02 -> o_rdata=16'hBEEF, o_rd_err=0 at o_done; master never drives during TA or DATA.
REQ-037 Read test with no PHY (pull-up only) -> o_rd_err=1 and o_rdata=16'hFFFF; a following write leaves both unchanged.
REQ-038 i_start pulsed mid-frame, and again in the o_done cycle -> first ignored with the frame unchanged; second accepted, with o_busy=1 the next cycle.
REQ-039 i_reset asserted at bit 20 of a write -> next cycle o_busy=0, o_mdc=0, io_mdio=Z, no o_done; a following read completes normally.
REQ-040 PREAMBLE_LEN=0, CLK_DIV=3 -> frame starts with ST; o_busy high for 192 cycles; MDC period is 6 cycles.
